// File: rtl/edge_event_unit.sv
// edge_event_unit: per-channel sync, debounce and edge pulse generation,
// with latched events offered by lowest-index priority over valid/ack.
module edge_event_unit #(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [N_CH-1:0] din,
  input  logic [1:0]      edge_mode,
  input  logic            evt_ack,
  output logic [N_CH-1:0] stable,
  output logic [N_CH-1:0] pulse,
  output logic            any_pulse,
  output logic            evt_valid,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_overflow
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DB_CYCLES - 1);

  logic [N_CH-1:0]  r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [N_CH];
  logic [N_CH-1:0]  r_stable;
  logic [N_CH-1:0]  r_pulse;
  logic [N_CH-1:0]  r_pending;
  logic             r_ovf;

  logic [N_CH-1:0] w_sync;
  logic [N_CH-1:0] w_hit;
  logic [N_CH-1:0] w_change;
  logic [N_CH-1:0] w_pulse_nx;
  logic [N_CH-1:0] w_ack_mask;
  logic [N_CH-1:0] w_lost;
  logic [CH_W-1:0] w_ch;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_CH; i++)
      w_hit[i] = (r_cnt[i] == CNT_TOP);
  end

  assign w_change = (w_sync ^ r_stable) & w_hit;

  // Masking with r_pulse keeps pulses one cycle apart when DB_CYCLES is 1.
  always_comb begin
    w_pulse_nx = '0;
    unique case (edge_mode)
      2'd0: w_pulse_nx = w_change & w_sync;
      2'd1: w_pulse_nx = w_change & ~w_sync;
      2'd2: w_pulse_nx = w_change;
      default: w_pulse_nx = '0;
    endcase
    w_pulse_nx = w_pulse_nx & ~r_pulse;
  end

  always_comb begin
    w_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (r_pending[i]) w_ch = CH_W'(i);
  end

  always_comb begin
    w_ack_mask = '0;
    if (evt_ack && (|r_pending))
      w_ack_mask[w_ch] = 1'b1;
  end

  assign w_lost = w_pulse_nx & r_pending & ~w_ack_mask;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        r_sync[s] <= '0;
    end else begin
      r_sync[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++)
        r_sync[s] <= r_sync[s-1];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++)
        r_cnt[i] <= '0;
      r_stable  <= '0;
      r_pulse   <= '0;
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N_CH; i++)
        r_cnt[i] <= '0;
      r_stable  <= w_sync;
      r_pulse   <= '0;
      r_pending <= '0;
      r_ovf     <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_hit[i]) begin
          r_stable[i] <= w_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_pulse   <= w_pulse_nx;
      r_pending <= (r_pending & ~w_ack_mask) | w_pulse_nx;
      if (|w_lost) r_ovf <= 1'b1;
    end
  end

  assign stable       = r_stable;
  assign pulse        = r_pulse;
  assign any_pulse    = |r_pulse;
  assign evt_valid    = |r_pending;
  assign evt_ch       = w_ch;
  assign evt_overflow = r_ovf;

endmodule

// File: tb/tb_edge_event_unit.sv
// tb_edge_event_unit: directed vector table plus hand-written
// sequences for glitch, modes, priority, overflow, reset and clear.
module tb_edge_event_unit;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [7:0] din;
  logic [1:0] edge_mode;
  logic       evt_ack;
  logic [7:0] stable;
  logic [7:0] pulse;
  logic       any_pulse;
  logic       evt_valid;
  logic [2:0] evt_ch;
  logic       evt_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  edge_event_unit dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .clear        (clear),
    .din          (din),
    .edge_mode    (edge_mode),
    .evt_ack      (evt_ack),
    .stable       (stable),
    .pulse        (pulse),
    .any_pulse    (any_pulse),
    .evt_valid    (evt_valid),
    .evt_ch       (evt_ch),
    .evt_overflow (evt_overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] din;
    logic [1:0] mode;
    logic       ack;
    logic [7:0] e_stable;
    logic [7:0] e_pulse;
    logic       e_valid;
    logic [2:0] e_ch;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    clear     = 1'b0;
    din       = '0;
    edge_mode = 2'd0;
    evt_ack   = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " stable"}, 32'(stable), 0);
    check({nm, " pulse"}, 32'(pulse), 0);
    check({nm, " any_pulse"}, 32'(any_pulse), 0);
    check({nm, " evt_valid"}, 32'(evt_valid), 0);
    check({nm, " evt_ch"}, 32'(evt_ch), 0);
    check({nm, " evt_overflow"}, 32'(evt_overflow), 0);
  endtask

  initial begin
    int npul;
    int bad;

    repeat (5) tbl.push_back('{8'h08, 2'd0, 1'b0,
                               8'h00, 8'h00, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{8'h08, 2'd0, 1'b0,
                    8'h08, 8'h08, 1'b1, 3'd3, 1'b0});
    tbl.push_back('{8'h08, 2'd0, 1'b0,
                    8'h08, 8'h00, 1'b1, 3'd3, 1'b0});
    repeat (5) tbl.push_back('{8'h00, 2'd0, 1'b0,
                               8'h08, 8'h00, 1'b1, 3'd3, 1'b0});
    tbl.push_back('{8'h00, 2'd0, 1'b0,
                    8'h00, 8'h00, 1'b1, 3'd3, 1'b0});
    tbl.push_back('{8'h00, 2'd0, 1'b1,
                    8'h00, 8'h00, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{8'h00, 2'd0, 1'b0,
                    8'h00, 8'h00, 1'b0, 3'd0, 1'b0});
    tbl.push_back('{8'h00, 2'd0, 1'b1,
                    8'h00, 8'h00, 1'b0, 3'd0, 1'b0});

    rst_n = 1'b0;
    clear = 1'b0;
    din = '0;
    edge_mode = 2'd0;
    evt_ack = 1'b0;
    #2;
    check_all_zero("reset");
    do_reset();

    foreach (tbl[k]) begin
      din       = tbl[k].din;
      edge_mode = tbl[k].mode;
      evt_ack   = tbl[k].ack;
      step();
      check($sformatf("vec%0d stable", k),
            32'(stable), 32'(tbl[k].e_stable));
      check($sformatf("vec%0d pulse", k),
            32'(pulse), 32'(tbl[k].e_pulse));
      check($sformatf("vec%0d any_pulse", k),
            32'(any_pulse), 32'(|tbl[k].e_pulse));
      check($sformatf("vec%0d evt_valid", k),
            32'(evt_valid), 32'(tbl[k].e_valid));
      check($sformatf("vec%0d evt_ch", k),
            32'(evt_ch), 32'(tbl[k].e_ch));
      check($sformatf("vec%0d evt_overflow", k),
            32'(evt_overflow), 32'(tbl[k].e_ovf));
    end
    evt_ack = 1'b0;

    // glitch: three cycles high is rejected
    do_reset();
    din = 8'h01;
    npul = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 4) din = 8'h00;
      step();
      if (pulse != 0) npul++;
    end
    check("glitch3 pulses", 32'(npul), 0);
    check("glitch3 stable", 32'(stable), 0);
    check("glitch3 valid", 32'(evt_valid), 0);

    // four cycles high is accepted at edge 6
    do_reset();
    din = 8'h01;
    steps(4);
    din = 8'h00;
    steps(2);
    check("glitch4 pulse", 32'(pulse), 32'h01);
    check("glitch4 stable", 32'(stable), 32'h01);
    check("glitch4 valid", 32'(evt_valid), 1);

    // mode 2 then mode 3 on channel 5
    for (int m = 2; m <= 3; m++) begin
      do_reset();
      edge_mode = 2'(m);
      din = 8'h20;
      npul = 0;
      bad = 0;
      for (int c = 1; c <= 30; c++) begin
        if (c == 11) din = 8'h00;
        step();
        if (pulse != 0) begin
          npul++;
          if (pulse != 8'h20) bad++;
        end
      end
      check($sformatf("mode%0d pulses", m),
            32'(npul), (m == 2) ? 2 : 0);
      check($sformatf("mode%0d pulse value", m),
            32'(bad), 0);
      check($sformatf("mode%0d valid", m),
            32'(evt_valid), (m == 2) ? 1 : 0);
    end

    // priority retire order 1, 4, 6
    do_reset();
    din = 8'h52;
    steps(6);
    check("prio pulse", 32'(pulse), 32'h52);
    check("prio ch0", 32'(evt_ch), 1);
    evt_ack = 1'b1;
    step();
    check("prio ch1", 32'(evt_ch), 4);
    check("prio valid1", 32'(evt_valid), 1);
    step();
    check("prio ch2", 32'(evt_ch), 6);
    check("prio valid2", 32'(evt_valid), 1);
    step();
    check("prio valid3", 32'(evt_valid), 0);
    check("prio ch3", 32'(evt_ch), 0);
    check("prio ovf", 32'(evt_overflow), 0);
    evt_ack = 1'b0;

    // overflow: second edge on pending channel 2
    do_reset();
    edge_mode = 2'd2;
    din = 8'h04;
    steps(6);
    check("ovf first pulse", 32'(pulse), 32'h04);
    din = 8'h00;
    steps(5);
    check("ovf before", 32'(evt_overflow), 0);
    step();
    check("ovf second pulse", 32'(pulse), 32'h04);
    check("ovf flag", 32'(evt_overflow), 1);
    check("ovf valid", 32'(evt_valid), 1);
    check("ovf ch", 32'(evt_ch), 2);

    // second edge coincides with the ack edge
    do_reset();
    edge_mode = 2'd2;
    din = 8'h04;
    steps(6);
    din = 8'h00;
    steps(5);
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    check("ackset pulse", 32'(pulse), 32'h04);
    check("ackset ovf", 32'(evt_overflow), 0);
    check("ackset valid", 32'(evt_valid), 1);
    check("ackset ch", 32'(evt_ch), 2);

    // asynchronous reset mid-debounce with event pending
    do_reset();
    din = 8'h08;
    steps(6);
    din = 8'h00;
    steps(3);
    check("rst pre valid", 32'(evt_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async rst");

    // clear re-baselines stable without a pulse
    do_reset();
    din = 8'h01;
    steps(6);
    check("clr pre valid", 32'(evt_valid), 1);
    din = 8'hFF;
    steps(3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr stable", 32'(stable), 32'hFF);
    check("clr pulse", 32'(pulse), 0);
    check("clr valid", 32'(evt_valid), 0);
    check("clr ovf", 32'(evt_overflow), 0);
    npul = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (pulse != 0) npul++;
    end
    check("clr later pulses", 32'(npul), 0);
    check("clr later stable", 32'(stable), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_unit.md
# edge_event_unit

Multi-channel successor to the single-output edge-to-pulse stage. Synchronises N_CH asynchronous switch/button inputs, debounces each channel, and produces one-cycle edge pulses under a selectable edge mode. Events are latched per channel and offered to the ALU control FSM through a valid/ack handshake with lowest-index priority. A sticky overflow flag marks lost events.

## Interface
- N_CH, 8, number of input channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (>=2)
- DB_CYCLES, 4, consecutive differing cycles required before a level is accepted (>=1)
- CH_W, max(1, clog2(N_CH)), derived width of evt_ch; not overridden
- clk_in  input  1  single clock; all state on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of event state (see Operation)
- din  input  N_CH  raw asynchronous inputs (sw/pb bits)
- edge_mode  input  2  0 = rising, 1 = falling, 2 = both, 3 = none (pulses suppressed)
- evt_ack  input  1  consumer accepts the currently offered event
- stable  output  N_CH  debounced level per channel
- pulse  output  N_CH  one-cycle edge pulse per channel
- any_pulse  output  1  OR of pulse
- evt_valid  output  1  at least one pending event
- evt_ch  output  CH_W  index of lowest pending channel; 0 when evt_valid = 0
- evt_overflow  output  1  sticky: an event arrived on a channel already pending

## Operation
- Sync: per channel, SYNC_STAGES-flop chain; the last stage is sync[i].
- Debounce: per channel, counter cnt[i] of width clog2(DB_CYCLES+1).
  - sync[i] == stable[i]: cnt[i] <= 0.
  - sync[i] != stable[i] and cnt[i] == DB_CYCLES-1: stable[i] <= sync[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments.
- Edge detection: on the edge where stable[i] changes, pulse[i] <= 1 if the change matches edge_mode; otherwise pulse[i] <= 0.
  - pulse is registered, so pulse and the new stable value are visible in the same cycle.
  - pulse is never high for two consecutive cycles.
- Pending: per-channel pending bits. The set condition is the pulse_next term, so pending sets on the same edge that pulse asserts.
  - evt_valid = |pending.
  - evt_ch = priority encode (lowest index) of pending, from registered state.
- Handshake: at an edge with evt_valid & evt_ack, pending[evt_ch] clears.
  - evt_ack while evt_valid = 0 is ignored.
  - evt_ch may change the cycle after an ack. The consumer must not assume the value is held.
- Simultaneous events:
  - A new pulse and an ack on the same channel at the same edge: the bit stays set (set wins) and evt_overflow is not raised.
  - A new pulse on a channel that is pending and not being acked: evt_overflow <= 1 (sticky). The pending bit stays 1; the count of events is lost.
- clear (synchronous, priority over everything except rst_n):
  - pending, evt_overflow, cnt and pulse go to 0.
  - stable <= sync, with no pulse generated.
  - The sync chains are unaffected.
- edge_mode is sampled each cycle. A change applies to transitions occurring at the next edge.

## Timing
- Reset (rst_n low, asynchronous): sync chains, cnt, stable, pulse, any_pulse, pending, evt_valid, evt_ch and evt_overflow are all 0.
- After reset, an input held high produces a rising event after the normal latency.
- Latency: din changes before edge 1 and stays constant. stable and pulse update at edge SYNC_STAGES+DB_CYCLES. With the defaults, pulse is high in the cycle after edge 6.
- evt_valid rises in the same cycle as the pulse that sets it.
- Glitch rejection: a sync deviation shorter than DB_CYCLES cycles produces no change in stable and no pulse.
- Ack throughput: one event retired per cycle. With all N_CH pending and evt_ack held high, evt_valid falls after N_CH edges.
- Deasserting rst_n mid-debounce discards partial counts. Asserting clear mid-debounce re-baselines stable to the current sync value.

## Test plan
- Defaults, edge_mode = 0: din[3] rises and is held. Required: pulse = 8'h08 for exactly one cycle after edge 6, any_pulse = 1, evt_valid = 1, evt_ch = 3. Falling din[3] with mode 0 gives no pulse.
- Glitch: din[0] high for 3 cycles, then low. Required: stable[0] stays 0, no pulse, evt_valid stays 0. Repeat with 4-cycle high after sync: pulse occurs.
- edge_mode = 2: toggle din[5] high, then low after 10 cycles. Required: two pulses, each on 8'h20. With mode 3 and the same stimulus: none.
- Priority/ack: pulse channels 6, 1 and 4 simultaneously; hold evt_ack = 1. Required: evt_ch sequence 1, 4, 6, then evt_valid = 0 on the 4th cycle. evt_overflow stays 0.
- Overflow: two debounced edges on channel 2 with no ack. Required: evt_overflow = 1 after the second pulse, pending[2] still set. A second edge landing on the ack edge gives no overflow and evt_valid stays 1 with evt_ch = 2.
- Reset/clear: assert rst_n = 0 asynchronously mid-debounce with events pending. Required: all outputs 0 immediately. Separately, pulse clear while din = 8'hFF is settled in sync: stable = 8'hFF, no pulse, pending = 0, evt_overflow = 0.
